ifm_tile_fetch: RTL and testbench

Fetches one input-feature-map tile, plus a PAD-pixel halo, from external memory into the local tile buffer. Out-of-image halo positions are filled with zeros. It sits directly downstream of the tile controller: it consumes `tile_start`, `tile_x`/`tile_y` and `ifm_base_addr`, and returns `tile_done` once the whole window is in the buffer. Memory reads use a valid/ready request channel with in-order responses and a bounded number of outstanding reads.

---
 rtl/ifm_tile_fetch.sv | 196 +++++++++++++++++++
 tb/tb_ifm_tile_fetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_tile_fetch.sv
`default_nettype none
// ifm_tile_fetch -- fetches one IFM tile plus a zero-filled halo into the tile buffer.
// Rev 1.0
module ifm_tile_fetch #(
   parameter int TILE_H     = 16,
   parameter int TILE_W     = 8,
   parameter int PAD        = 1,
   parameter int DATA_BYTES = 2,
   parameter int DATA_W     = 16,
   parameter int MAX_OUT    = 4,
   parameter int BUF_AW     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_tile_start,
   input  logic [15:0]       i_tile_x,
   input  logic [15:0]       i_tile_y,
   input  logic [15:0]       i_h,
   input  logic [15:0]       i_w,
   input  logic [31:0]       i_ifm_base_addr,
   output logic              o_mem_req_valid,
   input  logic              i_mem_req_ready,
   output logic [31:0]       o_mem_req_addr,
   input  logic              i_mem_rsp_valid,
   input  logic [DATA_W-1:0] i_mem_rsp_data,
   output logic              o_buf_we,
   output logic [BUF_AW-1:0] o_buf_waddr,
   output logic [DATA_W-1:0] o_buf_wdata,
   output logic              o_busy,
   output logic              o_tile_done
);

   localparam int WH  = TILE_H + 2*PAD;
   localparam int WW  = TILE_W + 2*PAD;
   localparam int RW  = $clog2(WH + 1);
   localparam int CW  = $clog2(WW);
   localparam int OCW = $clog2(MAX_OUT + 1);
   localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [31:0] c_DB    = 32'(DATA_BYTES);
   localparam logic [31:0] c_PAD32 = 32'(PAD);
   localparam logic [31:0] c_PADB  = 32'(PAD*DATA_BYTES);
   localparam logic [17:0] c_PAD18 = 18'(PAD);

   logic [1:0]        r_state, w_next;
   logic [15:0]       r_tx, r_ty, r_h, r_w;
   logic [31:0]       r_row_addr, r_elem_addr;
   logic [RW-1:0]     r_r;
   logic [CW-1:0]     r_c;
   logic [BUF_AW-1:0] r_idx;
   logic [OCW-1:0]    r_out_cnt;
   logic [BUF_AW-1:0] r_fifo [MAX_OUT];
   logic [PW-1:0]     r_wp, r_rp;
   logic              r_buf_we;
   logic [BUF_AW-1:0] r_buf_waddr;
   logic [DATA_W-1:0] r_buf_wdata;

   logic [17:0] w_row, w_col;
   logic        w_inb, w_issue, w_req_valid, w_req_fire, w_pad_fire, w_retire;
   logic        w_last, w_rsp_take, w_drain_done, w_start_ok;
   logic [31:0] w_row_step, w_init_row;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUT-1)) ? '0 : p + 1'b1;
   endfunction

   // Image coordinates of the current window element; bit 17 set means negative.
   assign w_row = {2'b00, r_ty} + 18'(r_r) - c_PAD18;
   assign w_col = {2'b00, r_tx} + 18'(r_c) - c_PAD18;
   assign w_inb = !w_row[17] && (w_row < {2'b00, r_h}) &&
                  !w_col[17] && (w_col < {2'b00, r_w});

   assign w_issue      = (r_state == S_ISSUE);
   assign w_req_valid  = w_issue && w_inb && (r_out_cnt < OCW'(MAX_OUT));
   assign w_req_fire   = w_req_valid && i_mem_req_ready;
   assign w_pad_fire   = w_issue && !w_inb && !i_mem_rsp_valid;
   assign w_retire     = w_req_fire || w_pad_fire;
   assign w_last       = (r_r == RW'(WH-1)) && (r_c == CW'(WW-1));
   assign w_rsp_take   = i_mem_rsp_valid && (r_out_cnt != '0);
   assign w_drain_done = (r_out_cnt == '0) || ((r_out_cnt == OCW'(1)) && i_mem_rsp_valid);
   assign w_start_ok   = (r_state == S_IDLE) && i_tile_start;
   assign w_row_step   = {16'b0, r_w} * c_DB;
   assign w_init_row   = i_ifm_base_addr - c_PAD32 * ({16'b0, i_w} * c_DB);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_tile_start)        w_next = S_ISSUE;
         S_ISSUE: if (w_retire && w_last)  w_next = S_DRAIN;
         S_DRAIN: if (w_drain_done)        w_next = S_DONE;
         S_DONE:                           w_next = S_IDLE;
         default:                          w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_mem_req_valid = w_req_valid;
      o_busy          = (r_state != S_IDLE);
      o_tile_done     = (r_state == S_DONE);
   end

   // Scan position and request address advance incrementally, avoiding a per-element multiply.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx        <= '0;
         r_ty        <= '0;
         r_h         <= '0;
         r_w         <= '0;
         r_r         <= '0;
         r_c         <= '0;
         r_idx       <= '0;
         r_row_addr  <= '0;
         r_elem_addr <= '0;
      end else if (w_start_ok) begin
         r_tx        <= i_tile_x;
         r_ty        <= i_tile_y;
         r_h         <= i_h;
         r_w         <= i_w;
         r_r         <= '0;
         r_c         <= '0;
         r_idx       <= '0;
         r_row_addr  <= w_init_row;
         r_elem_addr <= w_init_row - c_PADB;
      end else if (w_retire) begin
         r_idx <= r_idx + 1'b1;
         if (r_c == CW'(WW-1)) begin
            r_c         <= '0;
            r_r         <= r_r + 1'b1;
            r_row_addr  <= r_row_addr + w_row_step;
            r_elem_addr <= r_row_addr + w_row_step - c_PADB;
         end else begin
            r_c         <= r_c + 1'b1;
            r_elem_addr <= r_elem_addr + c_DB;
         end
      end
   end

   // Buffer addresses of in-flight reads; out_cnt doubles as the FIFO occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_cnt <= '0;
         r_wp      <= '0;
         r_rp      <= '0;
         for (int i = 0; i < MAX_OUT; i++) r_fifo[i] <= '0;
      end else if (w_start_ok) begin
         r_out_cnt <= '0;
         r_wp      <= '0;
         r_rp      <= '0;
      end else begin
         if (w_req_fire) begin
            r_fifo[r_wp] <= r_idx;
            r_wp         <= ptr_inc(r_wp);
         end
         if (w_rsp_take) r_rp <= ptr_inc(r_rp);
         case ({w_req_fire, w_rsp_take})
            2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
            2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
            default: r_out_cnt <= r_out_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf_we    <= 1'b0;
         r_buf_waddr <= '0;
         r_buf_wdata <= '0;
      end else begin
         r_buf_we <= w_rsp_take || w_pad_fire;
         if (w_rsp_take) begin
            r_buf_waddr <= r_fifo[r_rp];
            r_buf_wdata <= i_mem_rsp_data;
         end else if (w_pad_fire) begin
            r_buf_waddr <= r_idx;
            r_buf_wdata <= '0;
         end
      end
   end

   assign o_mem_req_addr = r_elem_addr;
   assign o_buf_we       = r_buf_we;
   assign o_buf_waddr    = r_buf_waddr;
   assign o_buf_wdata    = r_buf_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ifm_tile_fetch.sv
`default_nettype none
// tb_ifm_tile_fetch -- directed self-checking bench for ifm_tile_fetch.
// Rev 1.0
module tb_ifm_tile_fetch;

   localparam int WW  = 10;
   localparam int WIN = 180;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_tile_start = 1'b0;
   logic [15:0] i_tile_x = '0, i_tile_y = '0, i_h = '0, i_w = '0;
   logic [31:0] i_ifm_base_addr = '0;
   logic        o_mem_req_valid;
   logic        i_mem_req_ready = 1'b1;
   logic [31:0] o_mem_req_addr;
   logic        i_mem_rsp_valid = 1'b0;
   logic [15:0] i_mem_rsp_data = '0;
   logic        o_buf_we;
   logic [7:0]  o_buf_waddr;
   logic [15:0] o_buf_wdata;
   logic        o_busy, o_tile_done;

   always #5 clk = ~clk;

   ifm_tile_fetch dut (
      .clk(clk), .rst(rst),
      .i_tile_start(i_tile_start), .i_tile_x(i_tile_x), .i_tile_y(i_tile_y),
      .i_h(i_h), .i_w(i_w), .i_ifm_base_addr(i_ifm_base_addr),
      .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
      .o_mem_req_addr(o_mem_req_addr), .i_mem_rsp_valid(i_mem_rsp_valid),
      .i_mem_rsp_data(i_mem_rsp_data), .o_buf_we(o_buf_we), .o_buf_waddr(o_buf_waddr),
      .o_buf_wdata(o_buf_wdata), .o_busy(o_busy), .o_tile_done(o_tile_done)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   typedef struct { logic [31:0] addr; int due; } req_t;
   req_t        q[$];
   req_t        e;
   int          cyc = 0, t_start = 0;
   int          n_req, n_zero, stab_err, max_out, done_seen, done_cyc;
   bit          first_seen, prev_wait;
   logic [31:0] first_addr, prev_addr;
   logic [15:0] bufm [256];
   int          wcnt [256];
   int          wcyc [256];
   bit          rnd_ready = 1'b0;
   int          lat_lo = 1, lat_hi = 1;

   function automatic logic [15:0] pix(input logic [31:0] a);
      return {1'b1, a[15:1]};
   endfunction

   // Memory model and output monitor: observe at negedge, drive just after posedge.
   initial begin : mem_model
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (prev_wait && !(o_mem_req_valid && o_mem_req_addr == prev_addr)) stab_err++;
            prev_wait = o_mem_req_valid && !i_mem_req_ready;
            prev_addr = o_mem_req_addr;
            if (o_mem_req_valid && i_mem_req_ready) begin
               e.addr = o_mem_req_addr;
               e.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
               q.push_back(e);
               n_req++;
               if (!first_seen) begin first_seen = 1'b1; first_addr = o_mem_req_addr; end
               if (q.size() > max_out) max_out = q.size();
            end
            if (o_buf_we) begin
               wcnt[o_buf_waddr]++;
               bufm[o_buf_waddr] = o_buf_wdata;
               wcyc[o_buf_waddr] = cyc;
               if (o_buf_wdata == 16'h0) n_zero++;
            end
            if (o_tile_done) begin done_seen++; done_cyc = cyc; end
         end else begin
            prev_wait = 1'b0;
         end
         @(posedge clk);
         #1;
         cyc++;
         i_mem_rsp_valid = 1'b0;
         i_mem_rsp_data  = '0;
         if (!rst && q.size() > 0 && q[0].due <= cyc) begin
            i_mem_rsp_valid = 1'b1;
            i_mem_rsp_data  = pix(q[0].addr);
            void'(q.pop_front());
         end
         i_mem_req_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      end
   end

   task automatic start_tile(input int tx, input int ty, input int h, input int w,
                             input logic [31:0] base);
      for (int i = 0; i < 256; i++) begin bufm[i] = '0; wcnt[i] = 0; wcyc[i] = -1; end
      n_req = 0; n_zero = 0; stab_err = 0; max_out = 0; done_seen = 0; done_cyc = 0;
      first_seen = 1'b0; first_addr = '0;
      @(posedge clk); #2;
      i_tile_x = 16'(tx); i_tile_y = 16'(ty); i_h = 16'(h); i_w = 16'(w);
      i_ifm_base_addr = base;
      i_tile_start = 1'b1;
      t_start = cyc;
      @(posedge clk); #2;
      i_tile_start = 1'b0;
   endtask

   task automatic wait_done(input int ign_at);
      for (int k = 0; k < 3000 && done_seen == 0; k++) begin
         @(posedge clk); #2;
         i_tile_start = 1'b0;
         if (ign_at > 0 && cyc == t_start + ign_at) begin
            i_tile_x = 16'd0; i_tile_y = 16'd0; i_h = 16'd5; i_w = 16'd5;
            i_ifm_base_addr = 32'h0;
            i_tile_start = 1'b1;
         end
      end
      @(posedge clk); #2;
      i_tile_start = 1'b0;
   endtask

   task automatic verify(input string nm, input int tx, input int ty, input int h, input int w,
                         input logic [31:0] base, input int exp_req, input int exp_zero,
                         input int exp_lat, input logic [31:0] exp_first);
      int r, c, row, col, bad_data, bad_cnt;
      logic [15:0] ev;
      bad_data = 0; bad_cnt = 0;
      chk({nm, ".done_once"}, 32'(done_seen), 32'd1);
      if (exp_lat >= 0) chk({nm, ".done_latency"}, 32'(done_cyc - t_start), 32'(exp_lat));
      chk({nm, ".requests"}, 32'(n_req), 32'(exp_req));
      chk({nm, ".zero_writes"}, 32'(n_zero), 32'(exp_zero));
      chk({nm, ".first_addr"}, first_addr, exp_first);
      chk({nm, ".addr_stable"}, 32'(stab_err), 32'd0);
      chk({nm, ".outstanding_le4"}, 32'(max_out <= 4), 32'd1);
      for (int i = 0; i < 256; i++) begin
         if (i < WIN) begin
            r = i / WW; c = i % WW;
            row = ty - 1 + r; col = tx - 1 + c;
            if (row >= 0 && row < h && col >= 0 && col < w)
               ev = pix(base + 32'(((r - 1) * w + (c - 1)) * 2));
            else
               ev = 16'h0;
            if (bufm[i] !== ev) bad_data++;
            if (wcnt[i] != 1) bad_cnt++;
         end else if (wcnt[i] != 0) begin
            bad_cnt++;
         end
      end
      chk({nm, ".bad_data_words"}, 32'(bad_data), 32'd0);
      chk({nm, ".bad_write_counts"}, 32'(bad_cnt), 32'd0);
      chk({nm, ".idle_busy"}, 32'(o_busy), 32'd0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      repeat (3) @(posedge clk);
      #2;
      chk("reset.req_valid", 32'(o_mem_req_valid), 32'd0);
      chk("reset.req_addr", o_mem_req_addr, 32'd0);
      chk("reset.buf_we", 32'(o_buf_we), 32'd0);
      chk("reset.buf_waddr", 32'(o_buf_waddr), 32'd0);
      chk("reset.buf_wdata", 32'(o_buf_wdata), 32'd0);
      chk("reset.busy", 32'(o_busy), 32'd0);
      chk("reset.tile_done", 32'(o_tile_done), 32'd0);
      rst = 1'b0;

      // Interior tile, no pads.
      start_tile(8, 16, 64, 32, 32'd1040);
      chk("interior.busy_after_start", 32'(o_busy), 32'd1);
      wait_done(0);
      verify("interior", 8, 16, 64, 32, 32'd1040, 180, 0, 182, 32'd974);

      // Corner tile: every row-start pad collides with the previous row's last response.
      start_tile(0, 0, 32, 16, 32'd4096);
      wait_done(0);
      verify("corner", 0, 0, 32, 16, 32'd4096, 153, 27, 198, 32'd4096);
      chk("corner.addr11_pixel00", 32'(bufm[11]), 32'(pix(32'd4096)));
      chk("corner.collision_order", 32'(wcyc[20] - wcyc[19]), 32'd1);

      // Bottom-right partial tile.
      start_tile(8, 16, 20, 12, 32'h2000);
      wait_done(0);
      verify("partial", 8, 16, 20, 12, 32'h2000, 25, 155, 187, 32'd8166);

      // Backpressure with 3..8 cycle response latency.
      rnd_ready = 1'b1; lat_lo = 3; lat_hi = 8;
      start_tile(0, 8, 40, 24, 32'h3000);
      wait_done(0);
      verify("backpressure", 0, 8, 40, 24, 32'h3000, 162, 18, -1, 32'd12240);
      rnd_ready = 1'b0; lat_lo = 1; lat_hi = 1;

      // tile_start pulsed mid-fetch must be ignored.
      start_tile(8, 16, 64, 32, 32'd1040);
      wait_done(40);
      verify("ignored_start", 8, 16, 64, 32, 32'd1040, 180, 0, 182, 32'd974);

      // Reset mid-fetch.
      start_tile(8, 16, 64, 32, 32'd1040);
      repeat (25) begin @(posedge clk); #2; end
      #1;
      rst = 1'b1;
      q.delete();
      #1;
      chk("midreset.req_valid", 32'(o_mem_req_valid), 32'd0);
      chk("midreset.req_addr", o_mem_req_addr, 32'd0);
      chk("midreset.buf_we", 32'(o_buf_we), 32'd0);
      chk("midreset.busy", 32'(o_busy), 32'd0);
      chk("midreset.tile_done", 32'(o_tile_done), 32'd0);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (5) begin @(posedge clk); #2; end
      chk("midreset.no_tile_done", 32'(done_seen), 32'd0);

      start_tile(0, 0, 32, 16, 32'd4096);
      wait_done(0);
      verify("after_reset", 0, 0, 32, 16, 32'd4096, 153, 27, 198, 32'd4096);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
